link_chain_sched: RTL and testbench
===================================

# link_chain_sched

Cycle scheduler for the PRBS9 → tx filter → noise → channel filter → anti-alias filter → downsample-by-2 test chain. Generates the baud strobe for both PRBS generators, the sample clock-enable for all filter stages, and the decimation strobe. Manages a start/flush/run/drain sequence so that logged downsampled samples are flagged valid only once the filter pipelines are filled. Sits at the top level beside the datapath and replaces free-running enables.

## Interface
- OVERSAMP, 4, samples per baud; must be a multiple of DW_FACTOR
- DW_FACTOR, 2, decimation factor of the anti-alias output
- FLUSH_CYCLES, 64, pipeline fill/drain length in clk cycles (≥ 2)
- NB_PHASE, 2, width of i_phase (clog2 OVERSAMP)
- NB_FLUSH, 8, width of flush/drain counter (holds FLUSH_CYCLES-1)

- clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_start  in  1  start request, single-cycle pulse
- i_stop  in  1  stop request, single-cycle pulse
- i_phase  in  NB_PHASE  baud strobe phase within the oversample period, latched on accepted start
- o_samp_en  out  1  clock-enable for tx filter, noise, channel and AA filters
- o_prbs_en  out  1  one-cycle baud strobe to PRBS I and Q
- o_dw_en  out  1  decimation strobe
- o_valid  out  1  decimated sample is valid for capture
- o_busy  out  1  state ≠ IDLE
- o_state  out  2  IDLE=00, FLUSH=01, RUN=10, DRAIN=11

## Operation
- FSM states IDLE, FLUSH, RUN, DRAIN. All outputs are registered.
- IDLE: every enable is 0. i_start=1 moves to FLUSH and clears the sample index n and the flush counter. It latches phase_q = min(i_phase, OVERSAMP-1). i_stop is ignored in IDLE, including when it arrives together with i_start; start wins.
- Active cycle index n: counts from 0 at the first cycle with o_samp_en=1 and increments every active cycle. Only n mod OVERSAMP is kept.
- FLUSH/RUN: o_samp_en=1. o_prbs_en=1 iff n mod OVERSAMP == phase_q. o_dw_en=1 iff n mod DW_FACTOR == 0.
- FLUSH lasts exactly FLUSH_CYCLES cycles, then RUN. RUN holds until i_stop.
- i_stop in FLUSH or RUN moves to DRAIN and reloads the counter.
- DRAIN lasts FLUSH_CYCLES cycles. o_samp_en=1, o_prbs_en forced 0, o_dw_en keeps its phase because n keeps counting. Then the FSM goes to IDLE.
- o_valid = o_dw_en AND state ∈ {RUN, DRAIN}.
- i_start outside IDLE is ignored. i_stop in DRAIN is ignored.
- Reset (i_reset=0 at a rising edge) forces IDLE and counters to 0. Every output is 0 from the next cycle. This applies in any state, including mid-FLUSH and mid-DRAIN.

## Timing
- Start accepted at edge t: o_busy, o_samp_en and o_state=01 are high from edge t+1. That cycle is n=0.
- First o_prbs_en at n=phase_q. Subsequent strobes every OVERSAMP cycles, with no gaps across FLUSH→RUN.
- o_dw_en first at n=0, then every DW_FACTOR cycles.
- RUN is entered at n=FLUSH_CYCLES. The first o_valid is at the first n ≥ FLUSH_CYCLES with n mod DW_FACTOR == 0.
- Stop sampled at edge s: DRAIN from s+1. The last o_prbs_en is at or before cycle s. IDLE from s+1+FLUSH_CYCLES.
- Start-to-first-valid latency: FLUSH_CYCLES+1 cycles, rounded up to the DW_FACTOR grid.

## Configuration
- LINK_SCHED_STATS_EN defined: adds output o_baud_count (32 bits). It counts o_prbs_en pulses, clears on an accepted start and on reset, saturates at 2^32-1, and holds in IDLE.
- Not defined: the port and counter are absent. The behaviour of all other outputs is identical.

## Test plan
- Reset hold, then i_reset=1 with no start → all outputs 0, o_state=00 for 100 cycles.
- Defaults, i_phase=0, start at cycle 10 → o_samp_en from cycle 11. o_prbs_en at 11, 15, 19, … o_dw_en at 11, 13, … First o_valid at cycle 75, then every 2 cycles.
- i_phase=3, start, then i_phase changed mid-RUN → o_prbs_en at n=3, 7, 11, … Phase unchanged. i_phase=5 with NB_PHASE=3 clamps to 3.
- Stop in RUN at cycle s → o_prbs_en is 0 from s+1. o_valid continues through DRAIN. o_busy falls at s+1+64. Stop in FLUSH → DRAIN directly with o_valid=0 until the DRAIN state.
- Simultaneous i_start and i_stop in IDLE → FLUSH is entered. i_start in RUN → ignored.
- i_reset=0 mid-DRAIN → all outputs 0 next cycle. A new start behaves as in test 2. With LINK_SCHED_STATS_EN, 100 bauds give o_baud_count=100, which clears on restart.

Source files
------------

// File: rtl/link_chain_sched.sv
// Cycle scheduler for the PRBS/filter/decimation test chain: baud, sample and decimation strobes
// with a start/flush/run/drain sequence. Optional LINK_SCHED_STATS_EN adds o_baud_count.
module link_chain_sched #(
    parameter int OVERSAMP     = 4,
    parameter int DW_FACTOR    = 2,
    parameter int FLUSH_CYCLES = 64,
    parameter int NB_PHASE     = 2,
    parameter int NB_FLUSH     = 8
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_PHASE-1:0] i_phase,
    output logic                o_samp_en,
    output logic                o_prbs_en,
    output logic                o_dw_en,
    output logic                o_valid,
    output logic                o_busy,
`ifdef LINK_SCHED_STATS_EN
    output logic [31:0]         o_baud_count,
`endif
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FLUSH = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam logic [NB_PHASE-1:0] LAST_N = NB_PHASE'(OVERSAMP - 1);
    localparam logic [NB_FLUSH-1:0] LAST_F = NB_FLUSH'(FLUSH_CYCLES - 1);

    state_t              state, state_nx;
    logic [NB_PHASE-1:0] n, n_nx;
    logic [NB_PHASE-1:0] phase_q, phase_nx;
    logic [NB_FLUSH-1:0] cnt, cnt_nx;
    logic                start_acc;
    logic                samp_nx, prbs_nx, dw_nx, valid_nx;

    always_comb begin
        state_nx  = state;
        n_nx      = n;
        phase_nx  = phase_q;
        cnt_nx    = cnt;
        start_acc = 1'b0;

        if (state != IDLE) begin
            n_nx   = (n == LAST_N) ? '0 : n + NB_PHASE'(1);
            cnt_nx = cnt + NB_FLUSH'(1);
        end

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx  = FLUSH;
                    n_nx      = '0;
                    cnt_nx    = '0;
                    start_acc = 1'b1;
                    phase_nx  = (32'(i_phase) > 32'(OVERSAMP - 1)) ? LAST_N : i_phase;
                end
            end
            FLUSH: begin
                // stop wins over the flush-complete transition
                if (i_stop) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else if (cnt == LAST_F) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (i_stop) state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == LAST_F) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // outputs are computed from next-state values so they can be registered
        samp_nx  = (state_nx != IDLE);
        prbs_nx  = ((state_nx == FLUSH) || (state_nx == RUN)) && (n_nx == phase_nx);
        dw_nx    = samp_nx && ((32'(n_nx) % 32'(DW_FACTOR)) == 0);
        valid_nx = dw_nx && ((state_nx == RUN) || (state_nx == DRAIN));
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            n         <= '0;
            phase_q   <= '0;
            cnt       <= '0;
            o_samp_en <= 1'b0;
            o_prbs_en <= 1'b0;
            o_dw_en   <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nx;
            n         <= n_nx;
            phase_q   <= phase_nx;
            cnt       <= cnt_nx;
            o_samp_en <= samp_nx;
            o_prbs_en <= prbs_nx;
            o_dw_en   <= dw_nx;
            o_valid   <= valid_nx;
            o_busy    <= samp_nx;
        end
    end

    assign o_state = state;

`ifdef LINK_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!i_reset || start_acc) begin
            o_baud_count <= '0;
        end else if (o_prbs_en && (o_baud_count != '1)) begin
            o_baud_count <= o_baud_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_link_chain_sched.sv
// Self-checking bench for link_chain_sched: directed and randomized sessions checked against
// a per-cycle arithmetic model of the start/flush/run/drain timeline.
module tb_link_chain_sched;

    localparam int OS = 4;
    localparam int DW = 2;
    localparam int FC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] ph_in = '0;

    logic       n_samp, n_prbs, n_dw, n_valid, n_busy;
    logic [1:0] n_state;
    logic       w_samp, w_prbs, w_dw, w_valid, w_busy;
    logic [1:0] w_state;
`ifdef LINK_SCHED_STATS_EN
    logic [31:0] n_bc, w_bc;
`endif

    int tests = 0;
    int fails = 0;

    // model: edge count, session start edge (n=0 cycle), first drain cycle
    int  e = 0;
    bit  sess = 0;
    int  t0 = 0;
    int  td = -1;
    int  ph_n = 0;
    int  ph_w = 0;
    longint bc = 0;

    always #5 clk = ~clk;

    link_chain_sched #(.OVERSAMP(OS), .DW_FACTOR(DW), .FLUSH_CYCLES(FC), .NB_PHASE(2), .NB_FLUSH(8)) u_dut (
        .clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_phase(ph_in[1:0]),
        .o_samp_en(n_samp), .o_prbs_en(n_prbs), .o_dw_en(n_dw), .o_valid(n_valid), .o_busy(n_busy),
`ifdef LINK_SCHED_STATS_EN
        .o_baud_count(n_bc),
`endif
        .o_state(n_state)
    );

    link_chain_sched #(.OVERSAMP(OS), .DW_FACTOR(DW), .FLUSH_CYCLES(FC), .NB_PHASE(3), .NB_FLUSH(8)) u_dut_w (
        .clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_phase(ph_in),
        .o_samp_en(w_samp), .o_prbs_en(w_prbs), .o_dw_en(w_dw), .o_valid(w_valid), .o_busy(w_busy),
`ifdef LINK_SCHED_STATS_EN
        .o_baud_count(w_bc),
`endif
        .o_state(w_state)
    );

    // 0 idle, 1 flush, 2 run, 3 drain, for the cycle following edge k
    function automatic int st_at(int k);
        if (!sess || k < t0) return 0;
        if (td >= 0 && k >= td) return (k >= td + FC) ? 0 : 3;
        return (k - t0 >= FC) ? 2 : 1;
    endfunction

    function automatic bit exp_prbs(int k, int ph);
        int s = st_at(k);
        return (s == 1 || s == 2) && ((k - t0) % OS == ph);
    endfunction

    function automatic bit exp_dw(int k);
        return (st_at(k) != 0) && ((k - t0) % DW == 0);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        int prev;
        int s;
        @(posedge clk);
        e++;
        prev = st_at(e - 1);
        if (!rst) begin
            sess = 0;
            bc = 0;
        end else if (prev == 0 && start) begin
            sess = 1;
            t0 = e;
            td = -1;
            ph_n = int'(ph_in[1:0]);
            ph_w = (int'(ph_in) > OS - 1) ? OS - 1 : int'(ph_in);
            bc = 0;
        end else begin
            if (exp_prbs(e - 1, ph_n) && bc < 64'hFFFF_FFFF) bc++;
            if (stop && (prev == 1 || prev == 2)) td = e;
        end
        #1;
        s = st_at(e);
        chk("state", 32'(n_state), 32'(s));
        chk("busy", 32'(n_busy), 32'(s != 0));
        chk("samp_en", 32'(n_samp), 32'(s != 0));
        chk("prbs_en", 32'(n_prbs), 32'(exp_prbs(e, ph_n)));
        chk("dw_en", 32'(n_dw), 32'(exp_dw(e)));
        chk("valid", 32'(n_valid), 32'(exp_dw(e) && s >= 2));
        chk("w_state", 32'(w_state), 32'(s));
        chk("w_prbs_en", 32'(w_prbs), 32'(exp_prbs(e, ph_w)));
        chk("w_valid", 32'(w_valid), 32'(exp_dw(e) && s >= 2));
`ifdef LINK_SCHED_STATS_EN
        chk("baud_count", n_bc, 32'(bc));
`endif
    endtask

    task automatic ticks(int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        // reset hold, then idle with no start
        rst = 1'b0;
        ticks(5);
        rst = 1'b1;
        ticks(100);

        // phase 0 session, phase input changed mid-RUN, stop in RUN
        ph_in = 3'd0;
        ticks(4);
        pulse_start();
        ticks(90);
        ph_in = 3'(1 + $urandom_range(0, 6));
        ticks(10);
        pulse_stop();
        ticks(70);

        // phase 5: wide instance clamps to 3; stop during FLUSH
        ph_in = 3'd5;
        pulse_start();
        ticks(30);
        pulse_stop();
        ticks(70);

        // start+stop together in IDLE, start in RUN ignored, reset mid-DRAIN
        ph_in = 3'd3;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        ticks(80);
        pulse_start();
        ticks(10);
        pulse_stop();
        ticks(30);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ticks(3);
        ph_in = 3'd0;
        pulse_start();
        ticks(420);
        pulse_start();
        ticks(10);
        pulse_stop();
        ticks(70);

        // randomized sessions
        for (int it = 0; it < 8; it++) begin
            ph_in = 3'($urandom_range(0, 7));
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) begin
                stop = 1'($urandom_range(0, 1));
                tick();
            end
            stop = 1'($urandom_range(0, 1));
            pulse_start();
            for (int i = 0; i < int'($urandom_range(1, 150)); i++) begin
                start = ($urandom_range(0, 9) == 0);
                ph_in = 3'($urandom_range(0, 7));
                tick();
            end
            start = 1'b0;
            pulse_stop();
            for (int i = 0; i < int'($urandom_range(0, 70)); i++) begin
                stop = ($urandom_range(0, 4) == 0);
                start = ($urandom_range(0, 9) == 0);
                tick();
            end
            stop = 1'b0;
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            ticks(70);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
